subbytes_seq: RTL and testbench

- Multi-cycle AES SubBytes / InvSubBytes engine for a 128-bit state.
- It uses LANES byte-substitution units time-multiplexed over 16/LANES beats, with valid/ready handshakes on input and output.
- It sits between the round controller and ShiftRows, and replaces the fully parallel 16-sbox array when area matters.
- Forward or inverse direction is chosen per transaction.

---
 rtl/subbytes_seq.sv | 133 +++++++++++++
 tb/tb_subbytes_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_seq.sv
// Multi-cycle AES SubBytes / InvSubBytes engine: LANES byte substitutions per
// cycle over BEATS cycles, valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// RUN   | substituting LANES bytes per cycle in the working register
// DONE  | result presented on out_state until the consumer takes it
module subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dir,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_nxt;
  logic [3:0]   beat_q;
  logic         dir_q;
  logic         busy_q;
  logic [127:0] work_q;
  logic [127:0] work_sub;
  logic         last_beat;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // One inverter shared by both directions; only the affine steps differ.
  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    logic [7:0] t;
    logic [7:0] i;
    t = inv ? (rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05) : b;
    i = gf_inv(t);
    return inv ? i : (i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63);
  endfunction

  assign last_beat = (beat_q == 4'(BEATS - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = busy_q;

  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < LANES; l++) begin
      work_sub[127 - 8 * (int'(beat_q) * LANES + l) -: 8] =
        sbox(work_q[127 - 8 * (int'(beat_q) * LANES + l) -: 8], dir_q);
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beat_q    <= 4'd0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      work_q    <= 128'h0;
      out_state <= 128'h0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt != IDLE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q <= in_state;
            dir_q  <= in_dir;
            beat_q <= 4'd0;
          end
        end
        RUN: begin
          work_q <= work_sub;
          if (last_beat) begin
            beat_q    <= 4'd0;
            out_state <= work_sub;
          end else begin
            beat_q <= beat_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_seq.sv
// Bench for subbytes_seq: three instances (LANES 1, 4, 16) checked against
// known answers and an S-box model derived from GF(2^8) arithmetic.
module tb_subbytes_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid [3];
  logic         in_ready [3];
  logic         in_dir [3];
  logic [127:0] in_state [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    subbytes_seq #(.LANES(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_dir    (in_dir[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  function automatic int beats_of(input int idx);
    return (idx == 0) ? 16 : ((idx == 1) ? 4 : 1);
  endfunction

  // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 15; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ ('h11b << (i - 8));
    return p;
  endfunction

  task automatic build_tables();
    int inv, s, bitv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        bitv = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
                (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bitv << i);
      end
      fwd_t[x] = 8'(s);
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input logic d);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = st[127 - 8 * k -: 8];
      r[127 - 8 * k -: 8] = d ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input logic [127:0] st, input logic d,
                         output logic [127:0] res);
    int k;
    @(negedge clk);
    in_state[idx] = st;
    in_dir[idx]   = d;
    in_valid[idx] = 1'b1;
    k = 0;
    while (!in_ready[idx] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_at_accept", 128'(in_ready[idx]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    check("busy_in_run", 128'(busy[idx]), 128'd1);
    k = 0;
    while (!out_valid[idx] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("latency", 128'(k), 128'(beats_of(idx)));
    res = out_state[idx];
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    check("out_valid_after_hs", 128'(out_valid[idx]), 128'd0);
    check("in_ready_after_hs", 128'(in_ready[idx]), 128'd1);
  endtask

  typedef struct {
    int           idx;
    logic         d;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  initial begin
    vec_t         vecs [6];
    logic [127:0] res, res2, st, held, a_st, b_st;
    int           k, n_done;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_dir[i] = 1'b0; in_state[i] = '0; out_ready[i] = 1'b0;
    end
    build_tables();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_in_ready", 128'(in_ready[i]), 128'd1);
      check("reset_out_valid", 128'(out_valid[i]), 128'd0);
      check("reset_busy", 128'(busy[i]), 128'd0);
      check("reset_out_state", out_state[i], 128'h0);
    end
    reset_n = 1'b1;

    vecs[0] = '{1, 1'b0, PT, CT};
    vecs[1] = '{1, 1'b1, CT, PT};
    vecs[2] = '{0, 1'b0, PT, CT};
    vecs[3] = '{0, 1'b1, CT, PT};
    vecs[4] = '{2, 1'b0, PT, CT};
    vecs[5] = '{2, 1'b1, CT, PT};
    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].idx, vecs[v].st, vecs[v].d, res);
      check("known_answer", res, vecs[v].exp);
    end

    // All 256 byte values through the narrowest and widest instances.
    for (int idx = 0; idx < 3; idx += 2) begin
      for (int j = 0; j < 16; j++) begin
        for (int b = 0; b < 16; b++) st[127 - 8 * b -: 8] = 8'(16 * j + b);
        run_txn(idx, st, 1'b0, res);
        check("exhaustive_fwd", res, model(st, 1'b0));
        if (j == 0) check("fwd_00", 128'(res[127 -: 8]), 128'h63);
        if (j == 5) check("fwd_53", 128'(res[127 - 24 -: 8]), 128'hed);
        run_txn(idx, res, 1'b1, res2);
        check("round_trip", res2, st);
        run_txn(idx, st, 1'b1, res);
        check("exhaustive_inv", res, model(st, 1'b1));
        if (j == 0) check("inv_00", 128'(res[127 -: 8]), 128'h52);
      end
    end

    for (int idx = 0; idx < 3; idx++) begin
      for (int r = 0; r < 8; r++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        k = int'($urandom_range(0, 1));
        run_txn(idx, st, k[0], res);
        check("random", res, model(st, k[0]));
      end
    end

    // Backpressure on LANES=4.
    a_st = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_state[1] = a_st; in_dir[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    k = 0;
    while (!out_valid[1] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("bp_reach_done", 128'(out_valid[1]), 128'd1);
    held = out_state[1];
    check("bp_data", held, model(a_st, 1'b0));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid[1]), 128'd1);
      check("bp_out_state", out_state[1], held);
      check("bp_in_ready", 128'(in_ready[1]), 128'd0);
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    check("bp_release_in_ready", 128'(in_ready[1]), 128'd1);
    check("bp_release_out_state", out_state[1], held);
    b_st = {$urandom, $urandom, $urandom, $urandom};
    run_txn(1, b_st, 1'b1, res);
    check("bp_second", res, model(b_st, 1'b1));

    // New input offered during RUN must be ignored (LANES=1).
    a_st = {$urandom, $urandom, $urandom, $urandom};
    b_st = ~a_st;
    @(negedge clk);
    in_state[0] = a_st; in_dir[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    in_state[0] = b_st; in_dir[0] = 1'b1; in_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    in_valid[0] = 1'b0;
    k = 0;
    while (!out_valid[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ignore_data", out_state[0], model(a_st, 1'b0));
    out_ready[0] = 1'b1;
    @(negedge clk);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid[0]) n_done++;
    end
    out_ready[0] = 1'b0;
    check("ignore_single_completion", 128'(n_done), 128'd0);

    // Asynchronous reset at beat 7 of a LANES=1 transaction.
    a_st = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_state[0] = a_st; in_dir[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_reset_busy", 128'(busy[0]), 128'd1);
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_out_state", out_state[0], 128'h0);
    check("rst_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    b_st = {$urandom, $urandom, $urandom, $urandom};
    run_txn(0, b_st, 1'b0, res);
    check("post_reset_txn", res, model(b_st, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
